// File: rtl/io_timer.sv
// io_timer: banked 8-register IO timer with prescaler, reload, overflow IRQ and buffered 16-bit access.
// Optional input-capture unit is compiled in when IO_TIMER_CAPTURE_EN is defined.
module io_timer #(
  parameter logic [1:0] BANK = 2'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pause,
  input  logic [4:0] io_readaddr,
  output logic [7:0] io_readdata,
  input  logic [4:0] io_writeaddr,
  input  logic [7:0] io_writedata,
  input  logic       io_write_en,
`ifdef IO_TIMER_CAPTURE_EN
  input  logic       capture_in,
`endif
  output logic       irq
);
  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_STATUS    = 3'd1;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd2;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd3;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd4;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd5;
  localparam logic [2:0] OFF_CAP_LO    = 3'd6;
  localparam logic [2:0] OFF_CAP_HI    = 3'd7;

  logic        en_q, en_d, autoreload_q, autoreload_d, ien_q, ien_d;
  logic [2:0]  psc_q, psc_d;
  logic        ovf_q, ovf_d, capf_q, capf_d;
  logic [15:0] count_q, count_d, reload_q, reload_d;
  logic [7:0]  presc_q, presc_d, temp_q, temp_d;
  logic [7:0]  hi_latch_q, hi_latch_d, rdata_q, rdata_d;

  logic        wr_hit, rd_hit, ctrl_stop, count_wr, status_wr;
  logic        tick_raw, tick, ovf_set, cap_set;
  logic [2:0]  wr_off;
  logic [7:0]  psc_limit, rd_word;
  logic [15:0] cap_val;

  assign wr_hit    = io_write_en && (io_writeaddr[4:3] == BANK);
  assign wr_off    = io_writeaddr[2:0];
  assign rd_hit    = (io_readaddr[4:3] == BANK);
  assign ctrl_stop = wr_hit && (wr_off == OFF_CTRL) && !io_writedata[0];
  assign count_wr  = wr_hit && (wr_off == OFF_COUNT_LO);
  assign status_wr = wr_hit && (wr_off == OFF_STATUS);
  assign psc_limit = (8'd1 << psc_q) - 8'd1;
  assign tick_raw  = en_q && (presc_q == psc_limit);
  // A CPU COUNT write or an EN-clearing CTRL write swallows the tick of that cycle.
  assign tick      = tick_raw && !ctrl_stop && !count_wr;
  assign irq       = ovf_q & ien_q;
  assign io_readdata = rdata_q;

`ifdef IO_TIMER_CAPTURE_EN
  logic [2:0]  cap_sync_q;
  logic [15:0] cap_q;

  // Two synchronizer flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_sync_q <= '0;
      cap_q      <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture_in};
      if (cap_set) cap_q <= count_q;
    end
  end

  assign cap_set = cap_sync_q[1] & ~cap_sync_q[2];
  assign cap_val = cap_q;
`else
  assign cap_set = 1'b0;
  assign cap_val = 16'h0000;
`endif

  always_comb begin
    rd_word = 8'h00;
    case (io_readaddr[2:0])
      OFF_CTRL:      rd_word = {1'b0, psc_q, 1'b0, ien_q, autoreload_q, en_q};
      OFF_STATUS:    rd_word = {5'b0, capf_q, en_q, ovf_q};
      OFF_COUNT_LO:  rd_word = count_q[7:0];
      OFF_COUNT_HI:  rd_word = hi_latch_q;
      OFF_RELOAD_LO: rd_word = reload_q[7:0];
      OFF_RELOAD_HI: rd_word = reload_q[15:8];
      OFF_CAP_LO:    rd_word = cap_val[7:0];
      OFF_CAP_HI:    rd_word = cap_val[15:8];
      default:       rd_word = 8'h00;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    autoreload_d = autoreload_q;
    ien_d        = ien_q;
    psc_d        = psc_q;
    count_d      = count_q;
    reload_d     = reload_q;
    temp_d       = temp_q;
    hi_latch_d   = hi_latch_q;
    rdata_d      = rdata_q;
    ovf_set      = 1'b0;
    presc_d      = (!en_q || tick_raw) ? 8'd0 : presc_q + 8'd1;

    if (tick) begin
      if (count_q == 16'hFFFF) begin
        count_d = reload_q;
        ovf_set = 1'b1;
        if (!autoreload_q) en_d = 1'b0;
      end else begin
        count_d = count_q + 16'd1;
      end
    end

    if (wr_hit) begin
      case (wr_off)
        OFF_CTRL: begin
          en_d         = io_writedata[0];
          autoreload_d = io_writedata[1];
          ien_d        = io_writedata[2];
          psc_d        = io_writedata[6:4];
        end
        OFF_COUNT_LO:                temp_d   = temp_q;
        OFF_COUNT_HI, OFF_RELOAD_HI: temp_d   = io_writedata;
        OFF_RELOAD_LO:               reload_d = {temp_q, io_writedata};
        default:                     temp_d   = temp_q;
      endcase
    end
    if (count_wr) count_d = {temp_q, io_writedata};

    ovf_d  = (ovf_q  & ~(status_wr & io_writedata[0])) | ovf_set;
    capf_d = (capf_q & ~(status_wr & io_writedata[2])) | cap_set;

    if (!pause) begin
      rdata_d = rd_hit ? rd_word : 8'h00;
      if (rd_hit && (io_readaddr[2:0] == OFF_COUNT_LO)) hi_latch_d = count_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      ien_q        <= 1'b0;
      psc_q        <= 3'd0;
      ovf_q        <= 1'b0;
      capf_q       <= 1'b0;
      count_q      <= 16'h0000;
      reload_q     <= 16'h0000;
      presc_q      <= 8'h00;
      temp_q       <= 8'h00;
      hi_latch_q   <= 8'h00;
      rdata_q      <= 8'h00;
    end else begin
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      ien_q        <= ien_d;
      psc_q        <= psc_d;
      ovf_q        <= ovf_d;
      capf_q       <= capf_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      presc_q      <= presc_d;
      temp_q       <= temp_d;
      hi_latch_q   <= hi_latch_d;
      rdata_q      <= rdata_d;
    end
  end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: directed scenarios plus randomized count/overflow runs checked against an arithmetic model.
module tb_io_timer;
  localparam logic [4:0] A_CTRL   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h09;
  localparam logic [4:0] A_CLO    = 5'h0A;
  localparam logic [4:0] A_CHI    = 5'h0B;
  localparam logic [4:0] A_RLO    = 5'h0C;
  localparam logic [4:0] A_RHI    = 5'h0D;
  localparam logic [4:0] A_IDLE   = 5'h18;

  logic       clk = 1'b0;
  logic       reset_n, pause, io_write_en, irq;
  logic [4:0] io_readaddr, io_writeaddr;
  logic [7:0] io_readdata, io_writedata;
`ifdef IO_TIMER_CAPTURE_EN
  logic       capture_in;
`endif

  int checks = 0;
  int failures = 0;

  io_timer #(.BANK(2'd1)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pause        (pause),
    .io_readaddr  (io_readaddr),
    .io_readdata  (io_readdata),
    .io_writeaddr (io_writeaddr),
    .io_writedata (io_writedata),
    .io_write_en  (io_write_en),
`ifdef IO_TIMER_CAPTURE_EN
    .capture_in   (capture_in),
`endif
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    io_writeaddr = a;
    io_writedata = v;
    io_write_en  = 1'b1;
    @(negedge clk);
    io_write_en  = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    io_readaddr = a;
    @(negedge clk);
    v = io_readdata;
    io_readaddr = A_IDLE;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       ien, exp_ovf;
    int         psc, per, n, t, s, c0, rl, exp_c;

    reset_n = 1'b0; pause = 1'b0; io_write_en = 1'b0;
    io_readaddr = A_IDLE; io_writeaddr = 5'h00; io_writedata = 8'h00;
`ifdef IO_TIMER_CAPTURE_EN
    capture_in = 1'b0;
`endif
    idle(2);
    chk8("reset_rdata", io_readdata, 8'h00);
    chk1("reset_irq", irq, 1'b0);
    reset_n = 1'b1;
    for (int o = 0; o < 8; o++) begin
      rd(5'(8 + o), d);
      chk8("reset_reg", d, 8'h00);
    end

    // Bank decode and one-cycle read latency
    wr(A_CTRL, 8'h07);
    rd(A_CTRL, d);            chk8("ctrl_readback", d, 8'h07);
    wr(A_CTRL, 8'h00);
    wr(5'h10, 8'h55);
    rd(A_CTRL, d);            chk8("other_bank_write", d, 8'h00);
    rd(5'h10, d);             chk8("other_bank_read", d, 8'h00);

    // Autoreload overflow with IRQ
    wr(A_RHI, 8'hFF); wr(A_RLO, 8'hFE); wr(A_CHI, 8'hFF); wr(A_CLO, 8'hFE);
    wr(A_CTRL, 8'h07);
    idle(1);                  chk1("irq_before_ovf", irq, 1'b0);
    idle(1);                  chk1("irq_after_ovf", irq, 1'b1);
    io_readaddr = A_STATUS;
    wr(A_CTRL, 8'h06);        chk8("status_en_ovf", io_readdata, 8'h03);
    io_readaddr = A_IDLE;
    rd(A_CLO, d);             chk8("autoreload_lo", d, 8'hFE);
    rd(A_CHI, d);             chk8("autoreload_hi", d, 8'hFF);
    wr(A_STATUS, 8'h01);      chk1("irq_after_w1c", irq, 1'b0);
    rd(A_STATUS, d);          chk8("status_cleared", d, 8'h00);

    // One-shot overflow
    wr(A_RHI, 8'h13); wr(A_RLO, 8'h57); wr(A_CHI, 8'hFF); wr(A_CLO, 8'hFF);
    wr(A_CTRL, 8'h01);
    idle(1);                  chk1("oneshot_irq", irq, 1'b0);
    rd(A_STATUS, d);          chk8("oneshot_status", d, 8'h01);
    rd(A_CLO, d);             chk8("oneshot_lo", d, 8'h57);
    rd(A_CHI, d);             chk8("oneshot_hi", d, 8'h13);
    rd(A_CTRL, d);            chk8("oneshot_ctrl", d, 8'h00);
    wr(A_STATUS, 8'h01);

    // Prescaler 3: one tick per 8 cycles
    wr(A_CHI, 8'h00); wr(A_CLO, 8'h00);
    wr(A_CTRL, 8'h31);
    idle(16);
    wr(A_CTRL, 8'h30);
    rd(A_CLO, d);             chk8("psc3_lo", d, 8'h02);
    rd(A_CHI, d);             chk8("psc3_hi", d, 8'h00);

    // Overflow set beats simultaneous W1C
    wr(A_CHI, 8'hFF); wr(A_CLO, 8'hFF);
    wr(A_CTRL, 8'h03);
    wr(A_STATUS, 8'h01);
    wr(A_CTRL, 8'h02);
    rd(A_STATUS, d);          chk8("set_beats_clear", d, 8'h01);
    wr(A_STATUS, 8'h01);
    rd(A_STATUS, d);          chk8("w1c_after", d, 8'h00);

    // Buffered HI write, snapshot read, pause hold
    wr(A_CHI, 8'h12);
    rd(A_CLO, d);             chk8("hi_buffered", d, 8'h57);
    wr(A_CLO, 8'h34);
    io_readaddr = A_CLO;
    @(negedge clk);           chk8("atomic_lo", io_readdata, 8'h34);
    pause = 1'b1;
    io_readaddr = A_CHI;
    wr(A_CHI, 8'hAB);         chk8("pause_hold1", io_readdata, 8'h34);
    wr(A_CLO, 8'hCD);         chk8("pause_hold2", io_readdata, 8'h34);
    pause = 1'b0;
    @(negedge clk);           chk8("hi_snapshot", io_readdata, 8'h12);
    io_readaddr = A_IDLE;
    rd(A_CLO, d);             chk8("new_lo", d, 8'hCD);
    rd(A_CHI, d);             chk8("new_hi", d, 8'hAB);

    // Asynchronous reset mid-count
    wr(A_CHI, 8'hFF); wr(A_CLO, 8'hFE);
    wr(A_CTRL, 8'h07);
    idle(3);                  chk1("pre_reset_irq", irq, 1'b1);
    io_readaddr = A_CTRL;
    @(negedge clk);           chk8("pre_reset_ctrl", io_readdata, 8'h07);
    #2 reset_n = 1'b0;
    #1;
    chk1("async_reset_irq", irq, 1'b0);
    chk8("async_reset_rdata", io_readdata, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    io_readaddr = A_IDLE;
    for (int o = 0; o < 8; o++) begin
      rd(5'(8 + o), d);
      chk8("post_reset_reg", d, 8'h00);
    end

    // Randomized autoreload runs against an arithmetic model
    for (int it = 0; it < 30; it++) begin
      psc = int'($urandom_range(0, 3));
      per = 1 << psc;
      ien = 1'($urandom_range(0, 1));
      c0  = 65535 - int'($urandom_range(0, 20));
      rl  = 65520 + int'($urandom_range(0, 15));
      n   = int'($urandom_range(0, 60));
      wr(A_STATUS, 8'h01);
      wr(A_RHI, 8'(rl >> 8)); wr(A_RLO, 8'(rl));
      wr(A_CHI, 8'(c0 >> 8)); wr(A_CLO, 8'(c0));
      wr(A_CTRL, {1'b0, 3'(psc), 1'b0, ien, 2'b11});
      idle(n);
      t = n / per;
      s = 65536 - c0;
      if (t < s) begin
        exp_c = c0 + t;
        exp_ovf = 1'b0;
      end else begin
        exp_c = rl + (t - s) % (65536 - rl);
        exp_ovf = 1'b1;
      end
      chk1("rnd_irq", irq, exp_ovf & ien);
      wr(A_CTRL, {1'b0, 3'(psc), 1'b0, ien, 2'b10});
      rd(A_CLO, d);           chk8("rnd_count_lo", d, 8'(exp_c));
      rd(A_CHI, d);           chk8("rnd_count_hi", d, 8'(exp_c >> 8));
      rd(A_STATUS, d);        chk8("rnd_status", d, {7'b0, exp_ovf});
      $display("rnd it=%0d psc=%0d start=%h reload=%h cycles=%0d expect=%h ovf=%b",
               it, psc, 16'(c0), 16'(rl), n, 16'(exp_c), exp_ovf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
